pool_window_buffer: RTL and testbench

Raster-order window gatherer that sits directly upstream of the 2x2 max-pool stage. It accepts one pixel per valid cycle, carrying all NFMAPS feature maps, from the preceding convolution/activation stage. Internally it holds one image row. For every non-overlapping 2x2 block it emits a single-cycle packed window, with a valid strobe, in the exact bus layout the max-pool stage consumes.

---
 rtl/pool_window_buffer.sv | 100 ++++++++++
 tb/tb_pool_window_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_buffer.sv
// Raster-order 2x2 window gatherer feeding the max-pool stage.
// Optional frame_done strobe: define POOL_WIN_FRAME_DONE_EN.
module pool_window_buffer #(
  parameter int NBITS  = 32,
  parameter int NFMAPS = 32,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_valid,
  input  logic [NBITS*NFMAPS-1:0]    in_act,
  output logic                       out_valid,
  output logic [NBITS*4*NFMAPS-1:0]  out_act,
  output logic                       frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW = NBITS * NFMAPS;
  localparam int WW = NBITS * 4 * NFMAPS;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_last;
  logic          row_last;
  logic          emit;
  logic [CW-1:0] col_m1;

  logic [PW-1:0] line_q [IMG_W];
  logic [PW-1:0] hold_q;
  logic [WW-1:0] win;

  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign emit     = in_valid & row[0] & col[0];
  assign col_m1   = col - CW'(1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Storage is never cleared: every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (rstn && in_valid && !row[0])
      line_q[col] <= in_act;
  end

  always_ff @(posedge clk) begin
    if (rstn && in_valid && row[0] && !col[0])
      hold_q <= in_act;
  end

  always_comb begin
    win = '0;
    for (int i = 0; i < NFMAPS; i++) begin
      win[i*4*NBITS           +: NBITS] = line_q[col_m1][i*NBITS +: NBITS];
      win[i*4*NBITS + NBITS   +: NBITS] = line_q[col][i*NBITS +: NBITS];
      win[i*4*NBITS + 2*NBITS +: NBITS] = hold_q[i*NBITS +: NBITS];
      win[i*4*NBITS + 3*NBITS +: NBITS] = in_act[i*NBITS +: NBITS];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_act   <= '0;
    end else begin
      out_valid <= emit;
      if (emit)
        out_act <= win;
    end
  end

`ifdef POOL_WIN_FRAME_DONE_EN
  logic fd_q;

  always_ff @(posedge clk) begin
    if (!rstn)
      fd_q <= 1'b0;
    else
      fd_q <= emit & col_last & row_last;
  end

  assign frame_done = fd_q;
`else
  assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_pool_window_buffer.sv
// Scoreboard bench for pool_window_buffer, 4x4 image, 2 fmaps of 8 bits.
// Expected windows are queued by stimulus and popped by the monitor.
module tb_pool_window_buffer;

  localparam int NB = 8;
  localparam int NF = 2;
  localparam int W  = 4;
  localparam int H  = 4;

`ifdef POOL_WIN_FRAME_DONE_EN
  localparam bit FD_EN = 1'b1;
`else
  localparam bit FD_EN = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] act;
    logic        fd;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic [15:0] in_act;
  logic        out_valid;
  logic [63:0] out_act;
  logic        frame_done;

  pool_window_buffer #(
    .NBITS (NB),
    .NFMAPS(NF),
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_act    (in_act),
    .out_valid (out_valid),
    .out_act   (out_act),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed windows for the base frame: {fmap1 k3..k0, fmap0 k3..k0}.
  logic [63:0] wtab [4];
  initial begin
    wtab[0] = 64'h69686564_05040100;
    wtab[1] = 64'h6B6A6766_07060302;
    wtab[2] = 64'h71706D6C_0D0C0908;
    wtab[3] = 64'h73726F6E_0F0E0B0A;
  end

  localparam logic [63:0] OFF50 = {8{8'd50}};

  exp_t        q[$];
  int          checks;
  int          errors;
  int          pulses;
  bit          stable_chk;
  logic [63:0] last_act;

  initial begin
    checks     = 0;
    errors     = 0;
    pulses     = 0;
    stable_chk = 1'b0;
    last_act   = '0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (out_valid) begin
        pulses++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window act=%h required=none", out_act);
        end else begin
          e = q.pop_front();
          checks++;
          if (out_act !== e.act) begin
            errors++;
            $display("FAIL window act=%h required=%h", out_act, e.act);
          end
          checks++;
          if (frame_done !== e.fd) begin
            errors++;
            $display("FAIL frame_done got=%b required=%b", frame_done, e.fd);
          end
        end
      end else if (stable_chk) begin
        checks++;
        if (out_act !== last_act || frame_done !== 1'b0) begin
          errors++;
          $display("FAIL hold act=%h required=%h fd=%b",
                   out_act, last_act, frame_done);
        end
      end
    end
    last_act = out_act;
  end

  task automatic cyc(input logic v, input logic [15:0] d);
    in_valid = v;
    in_act   = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [15:0] pix(input int r, input int c, input int off);
    logic [7:0] f0;
    logic [7:0] f1;
    f0 = 8'(4*r + c + off);
    f1 = 8'(100 + 4*r + c + off);
    return {f1, f0};
  endfunction

  task automatic send_frame(input int off, input bit gaps, input bit neg);
    logic [15:0] p;
    exp_t        e;
    int          idx;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        p = pix(r, c, off);
        if (neg && r == 0 && c == 0) p[7:0] = 8'h80;
        if ((r % 2) == 1 && (c % 2) == 1) begin
          idx   = (r / 2) * 2 + (c / 2);
          e.act = wtab[idx] + ((off != 0) ? OFF50 : 64'd0);
          if (neg && idx == 0) e.act[7:0] = 8'h80;
          e.fd  = FD_EN && (idx == 3);
          q.push_back(e);
        end
        cyc(1'b1, p);
        if (gaps) begin
          repeat ($urandom_range(0, 2)) cyc(1'b0, 16'hDEAD);
        end
      end
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (out_valid !== 1'b0 || out_act !== 64'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s v=%b act=%h fd=%b required=0", tag,
               out_valid, out_act, frame_done);
    end
  endtask

  initial begin
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_act   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rstn = 1'b1;

    send_frame(0, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 16'h0);

    stable_chk = 1'b1;
    send_frame(0, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 16'h0);
    stable_chk = 1'b0;

    send_frame(0, 1'b0, 1'b0);
    send_frame(50, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 16'h0);

    for (int i = 0; i < 5; i++) cyc(1'b1, pix(i / W, i % W, 0));
    rstn     = 1'b0;
    in_valid = 1'b1;
    in_act   = pix(1, 1, 0);
    @(posedge clk);
    #1;
    rstn     = 1'b1;
    in_valid = 1'b0;
    check_zero("mid_frame_reset");
    send_frame(0, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 16'h0);

    send_frame(0, 1'b0, 1'b1);
    repeat (4) cyc(1'b0, 16'h0);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending got=%0d required=0", q.size());
    end
    checks++;
    if (pulses != 24) begin
      errors++;
      $display("FAIL pulse_count got=%0d required=24", pulses);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
